// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: state encoding and
// elaboration-time sizing helpers.
package serial_arith_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

  // Number of digit steps needed to cover the full operand width.
  function automatic int unsigned ndigits(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // A single-step operation still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its MSB so
// the caller can derive two's-complement overflow on the final digit.
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: consumes DIGIT bits per cycle LSB first and
// publishes the full sum, carry-out and overflow together with a done pulse.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [DIGIT-1:0] f_ser,
  output logic             f_valid
);

  localparam int unsigned N  = ndigits(WIDTH, DIGIT);
  localparam int unsigned CW = cnt_width(N);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_addsub: DIGIT must be in 1..WIDTH, divide WIDTH, and WIDTH >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_c;
  logic             dig_cmsb;
  logic [WIDTH-1:0] res_shift;
  logic             last_digit;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .a   (opa_q[DIGIT-1:0]),
    .b   (opb_q[DIGIT-1:0]),
    .cin (carry_q),
    .s   (dig_s),
    .cout(dig_c),
    .cmsb(dig_cmsb)
  );

  // New digit enters at the MSB end so the final digit lands the word in place.
  assign res_shift  = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
  assign last_digit = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        carry_d = dig_c;
        res_d   = res_shift;
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          cnt_d   = '0;
          sum_d   = res_shift;
          cout_d  = dig_c;
          ovf_d   = dig_cmsb ^ dig_c;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign f_valid = busy;
  assign f_ser   = busy ? dig_s : '0;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: one DIGIT=1 and one DIGIT=4 instance, driven with
// directed and random operations and compared against an arithmetic model.
module tb_serial_addsub;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sel;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;

  logic       start1, start4;
  logic       busy1, done1, cout1, ovf1, fv1;
  logic       busy4, done4, cout4, ovf4, fv4;
  logic [7:0] sum1, sum4;
  logic [0:0] fs1;
  logic [3:0] fs4;

  logic       o_busy, o_done, o_cout, o_ovf, o_fv;
  logic [7:0] o_sum;
  logic [3:0] o_fs;

  int n_checks;
  int n_errors;

  assign start1 = start & ~sel;
  assign start4 = start & sel;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1),
    .f_ser(fs1), .f_valid(fv1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4),
    .f_ser(fs4), .f_valid(fv4)
  );

  always_comb begin
    o_busy = sel ? busy4 : busy1;
    o_done = sel ? done4 : done1;
    o_cout = sel ? cout4 : cout1;
    o_ovf  = sel ? ovf4  : ovf1;
    o_fv   = sel ? fv4   : fv1;
    o_sum  = sel ? sum4  : sum1;
    o_fs   = sel ? fs4   : {3'b000, fs1};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one operation starting at the current negedge; optionally pulses a
  // conflicting start mid-run, which must be ignored.
  task automatic do_op(input logic s, input logic [7:0] ia, input logic [7:0] ib,
                       input logic isub, input bit inject);
    logic [8:0] full;
    logic [7:0] exp_sum;
    logic       exp_cout, exp_ovf;
    int         n, dw;
    if (isub) full = {1'b0, ia} + {1'b0, ~ib} + 9'd1;
    else      full = {1'b0, ia} + {1'b0, ib};
    exp_sum  = full[7:0];
    exp_cout = full[8];
    if (isub) exp_ovf = (ia[7] != ib[7]) && (exp_sum[7] != ia[7]);
    else      exp_ovf = (ia[7] == ib[7]) && (exp_sum[7] != ia[7]);
    dw = s ? 4 : 1;
    n  = 8 / dw;

    sel = s; start = 1'b1; a = ia; b = ib; sub = isub;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; sub = 1'($urandom);
      if (inject && i == 1) begin
        start = 1'b1; a = ~ia; b = ib ^ 8'h5A; sub = ~isub;
      end
      check("busy", 32'(o_busy), 32'd1);
      check("f_valid", 32'(o_fv), 32'd1);
      check("f_ser", 32'(o_fs), 32'((exp_sum >> (i * dw)) & ((8'd1 << dw) - 8'd1)));
      check("done_in_run", 32'(o_done), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    check("done", 32'(o_done), 32'd1);
    check("busy_at_done", 32'(o_busy), 32'd0);
    check("fser_idle", 32'(o_fs), 32'd0);
    check("sum", 32'(o_sum), 32'(exp_sum));
    check("cout", 32'(o_cout), 32'(exp_cout));
    check("ovf", 32'(o_ovf), 32'(exp_ovf));
    @(negedge clk);
    check("done_single", 32'(o_done), 32'd0);
    check("sum_held", 32'(o_sum), 32'(exp_sum));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; sel = 1'b0; sub = 1'b0; a = '0; b = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_sum", 32'(o_sum), 32'd0);
      check("rst_cout", 32'(o_cout), 32'd0);
      check("rst_ovf", 32'(o_ovf), 32'd0);
      check("rst_fv", 32'(o_fv), 32'd0);
      check("rst_fser", 32'(o_fs), 32'd0);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b0, 8'h35, 8'h4A, 1'b0, 1'b0);
    do_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
    do_op(1'b0, 8'h05, 8'h07, 1'b1, 1'b0);
    do_op(1'b0, 8'h80, 8'h01, 1'b1, 1'b0);
    do_op(1'b0, 8'h12, 8'h34, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a run.
    sel = 1'b0; start = 1'b1; a = 8'h35; b = 8'h4A; sub = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_fv", 32'(o_fv), 32'd0);
    check("arst_done", 32'(o_done), 32'd0);
    check("arst_sum", 32'(o_sum), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(o_busy), 32'd0);
    check("post_rst_done", 32'(o_done), 32'd0);
    do_op(1'b0, 8'h35, 8'h4A, 1'b0, 1'b0);

    // DIGIT=4: the second call starts on the cycle after done.
    do_op(1'b1, 8'h35, 8'h4A, 1'b0, 1'b0);
    do_op(1'b1, 8'h80, 8'h01, 1'b1, 1'b0);
    do_op(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1);

    for (int r = 0; r < 40; r++) begin
      do_op(1'(r % 2), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
